// File: rtl/alu_issue.sv
// alu_issue: single-issue front end for MIPS R-type words. It owns a 32x32
// register file, hands R[rs]/R[rt]/shamt/funct to an external ALU, waits a
// fixed ALU_LAT cycles and writes the result back to R[rd]. One instruction
// is in flight at a time, so no forwarding is needed.
module alu_issue #(
    parameter int ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    input  logic        ld_en,
    input  logic [4:0]  ld_addr,
    input  logic [31:0] ld_data,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_shamt,
    output logic [5:0]  alu_funct,
    output logic        alu_valid,
    input  logic [31:0] alu_out,
    output logic        wb_en,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data,
    output logic [7:0]  ill_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WAIT = 2'd2,
        WB   = 2'd3
    } state_t;

    // WAIT spans ALU_LAT-1 cycles; the counter is loaded with one less than that.
    localparam int         WAIT_CYC  = (ALU_LAT > 1) ? ALU_LAT - 2 : 0;
    localparam logic [1:0] WAIT_INIT = 2'(WAIT_CYC);

    state_t      state_q;
    logic [1:0]  wait_cnt_q;
    logic [31:0] rf_q [32];
    logic [31:0] alu_a_q;
    logic [31:0] alu_b_q;
    logic [4:0]  alu_shamt_q;
    logic [5:0]  alu_funct_q;
    logic        alu_valid_q;
    logic [4:0]  rd_q;
    logic [7:0]  ill_cnt_q;
    logic [7:0]  ill_cnt_d;

    logic [5:0]  instr_op;
    logic [4:0]  instr_rs;
    logic [4:0]  instr_rt;
    logic [4:0]  instr_rd;
    logic [4:0]  instr_shamt;
    logic [5:0]  instr_funct;
    logic        is_idle;
    logic        accept;
    logic        legal_accept;
    logic        illegal_accept;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] wb_hit;
    logic [31:0] ld_hit;

    assign instr_op    = instr[31:26];
    assign instr_rs    = instr[25:21];
    assign instr_rt    = instr[20:16];
    assign instr_rd    = instr[15:11];
    assign instr_shamt = instr[10:6];
    assign instr_funct = instr[5:0];

    assign is_idle        = (state_q == IDLE);
    assign instr_ready    = is_idle & rst_n;
    assign accept         = instr_valid & instr_ready;
    assign legal_accept   = accept & (instr_op == 6'd0);
    assign illegal_accept = accept & (instr_op != 6'd0);

    // R0 always reads as zero regardless of the flop contents.
    assign rs_data  = (instr_rs == 5'd0) ? 32'd0 : rf_q[instr_rs];
    assign rt_data  = (instr_rt == 5'd0) ? 32'd0 : rf_q[instr_rt];
    assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : rf_q[dbg_addr];

    assign ill_cnt_d = (ill_cnt_q == 8'hFF) ? ill_cnt_q : ill_cnt_q + 8'd1;

    // Writeback is driven straight from the ALU result during the WB cycle;
    // rst_n gates it so an abandoned instruction never shows a strobe.
    assign wb_en   = (state_q == WB) && (rd_q != 5'd0) && rst_n;
    assign wb_addr = wb_en ? rd_q : 5'd0;
    assign wb_data = wb_en ? alu_out : 32'd0;

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_shamt = alu_shamt_q;
    assign alu_funct = alu_funct_q;
    assign alu_valid = alu_valid_q;
    assign ill_cnt   = ill_cnt_q;

    // Decode one-hot write enables; loads only land while idle, never on R0.
    always_comb begin
        wb_hit = '0;
        ld_hit = '0;
        if (wb_en) begin
            wb_hit[wb_addr] = 1'b1;
        end
        if (ld_en && is_idle && (ld_addr != 5'd0)) begin
            ld_hit[ld_addr] = 1'b1;
        end
    end

    // Issue sequencer: capture operands on accept, then EXEC -> (WAIT) -> WB.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wait_cnt_q  <= 2'd0;
            alu_a_q     <= 32'd0;
            alu_b_q     <= 32'd0;
            alu_shamt_q <= 5'd0;
            alu_funct_q <= 6'd0;
            alu_valid_q <= 1'b0;
            rd_q        <= 5'd0;
            ill_cnt_q   <= 8'd0;
        end else begin
            alu_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (legal_accept) begin
                        alu_a_q     <= rs_data;
                        alu_b_q     <= rt_data;
                        alu_shamt_q <= instr_shamt;
                        alu_funct_q <= instr_funct;
                        rd_q        <= instr_rd;
                        alu_valid_q <= 1'b1;
                        state_q     <= EXEC;
                    end else if (illegal_accept) begin
                        ill_cnt_q <= ill_cnt_d;
                    end
                end
                EXEC: begin
                    if (ALU_LAT > 1) begin
                        state_q    <= WAIT;
                        wait_cnt_q <= WAIT_INIT;
                    end else begin
                        state_q <= WB;
                    end
                end
                WAIT: begin
                    if (wait_cnt_q == 2'd0) begin
                        state_q <= WB;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 2'd1;
                    end
                end
                WB: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Register file: one flop word per register, written by WB or by a preload.
    for (genvar gi = 0; gi < 32; gi++) begin : g_rf
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                rf_q[gi] <= 32'd0;
            end else if (wb_hit[gi]) begin
                rf_q[gi] <= alu_out;
            end else if (ld_hit[gi]) begin
                rf_q[gi] <= ld_data;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: two instances (ALU_LAT=1 and ALU_LAT=3) driven one at a time.
// Expected ALU transactions and writebacks are queued when an instruction is
// issued; a monitor pops and compares whenever the DUT presents them.
module tb_alu_issue;

    localparam int NI = 2;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [5:0]  fn;
    } alu_exp_t;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n       [NI];
    logic        instr_valid [NI];
    logic [31:0] instr       [NI];
    logic        instr_ready [NI];
    logic        ld_en       [NI];
    logic [4:0]  ld_addr     [NI];
    logic [31:0] ld_data     [NI];
    logic [31:0] alu_a       [NI];
    logic [31:0] alu_b       [NI];
    logic [4:0]  alu_shamt   [NI];
    logic [5:0]  alu_funct   [NI];
    logic        alu_valid   [NI];
    logic [31:0] alu_out     [NI];
    logic        wb_en       [NI];
    logic [4:0]  wb_addr     [NI];
    logic [31:0] wb_data     [NI];
    logic [4:0]  dbg_addr    [NI];
    logic [31:0] dbg_data    [NI];
    logic [7:0]  ill_cnt     [NI];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_rf  [NI][32];
    int          model_ill [NI];
    alu_exp_t    q_alu[$];
    wb_exp_t     q_wb[$];

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        alu_issue #(.ALU_LAT((gi == 0) ? 1 : 3)) u_dut (
            .clk         (clk),
            .rst_n       (rst_n[gi]),
            .instr_valid (instr_valid[gi]),
            .instr       (instr[gi]),
            .instr_ready (instr_ready[gi]),
            .ld_en       (ld_en[gi]),
            .ld_addr     (ld_addr[gi]),
            .ld_data     (ld_data[gi]),
            .alu_a       (alu_a[gi]),
            .alu_b       (alu_b[gi]),
            .alu_shamt   (alu_shamt[gi]),
            .alu_funct   (alu_funct[gi]),
            .alu_valid   (alu_valid[gi]),
            .alu_out     (alu_out[gi]),
            .wb_en       (wb_en[gi]),
            .wb_addr     (wb_addr[gi]),
            .wb_data     (wb_data[gi]),
            .dbg_addr    (dbg_addr[gi]),
            .dbg_data    (dbg_data[gi]),
            .ill_cnt     (ill_cnt[gi])
        );
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'd0, rs, rt, rd, sh, fn};
    endfunction

    // Behavioural ALU used both to answer the DUT and to predict results.
    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [4:0] sh, input logic [5:0] fn);
        case (fn)
            6'h00:   return b << sh;
            6'h02:   return b >> sh;
            6'h21:   return a + b;
            6'h23:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h3f:   return 32'hDEADBEEF;
            default: return a + b + {26'd0, fn};
        endcase
    endfunction

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (dut%0d): got 0x%08h, want 0x%08h", name, d, act, exp);
        end
    endtask

    // ALU stand-in: result appears exactly ALU_LAT cycles after alu_valid, noise otherwise.
    initial begin : alu_model
        int          cd  [NI];
        logic [31:0] res [NI];
        for (int d = 0; d < NI; d++) begin
            cd[d]      = 0;
            res[d]     = 32'd0;
            alu_out[d] = 32'd0;
        end
        forever begin
            @(posedge clk);
            #2;
            for (int d = 0; d < NI; d++) begin
                if (cd[d] > 0) begin
                    cd[d]--;
                    alu_out[d] = (cd[d] == 0) ? res[d] : $urandom();
                end else begin
                    alu_out[d] = $urandom();
                end
                if (alu_valid[d]) begin
                    res[d] = alu_fn(alu_a[d], alu_b[d], alu_shamt[d], alu_funct[d]);
                    cd[d]  = lat_of(d);
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every alu_valid / wb_en and checks idle writeback outputs.
    initial begin : monitor
        int       last_av [NI];
        alu_exp_t ea;
        wb_exp_t  ew;
        for (int d = 0; d < NI; d++) last_av[d] = 0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < NI; d++) begin
                if (alu_valid[d]) begin
                    last_av[d] = cyc;
                    if (q_alu.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL alu_valid_unexpected (dut%0d): got 1, want 0", d);
                    end else begin
                        ea = q_alu.pop_front();
                        chk("alu_a", d, alu_a[d], ea.a);
                        chk("alu_b", d, alu_b[d], ea.b);
                        chk("alu_shamt", d, 32'(alu_shamt[d]), 32'(ea.sh));
                        chk("alu_funct", d, 32'(alu_funct[d]), 32'(ea.fn));
                    end
                end
                if (wb_en[d]) begin
                    if (q_wb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL wb_en_unexpected (dut%0d): got 1 addr %0d, want 0", d, wb_addr[d]);
                    end else begin
                        ew = q_wb.pop_front();
                        chk("wb_addr", d, 32'(wb_addr[d]), 32'(ew.addr));
                        chk("wb_data", d, wb_data[d], ew.data);
                        chk("wb_latency", d, 32'(cyc - last_av[d]), 32'(lat_of(d)));
                    end
                end else begin
                    chk("wb_addr_idle", d, 32'(wb_addr[d]), 32'd0);
                    chk("wb_data_idle", d, wb_data[d], 32'd0);
                end
            end
        end
    end

    // All driving tasks start and end at posedge+1.
    task automatic wait_idle(input int d);
        int n = 0;
        @(negedge clk);
        while (!instr_ready[d] && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!instr_ready[d]) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout (dut%0d): got busy, want ready within 50 cycles", d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int d, input logic [4:0] a, input logic [31:0] v);
        int n = 0;
        ld_en[d]   = 1'b1;
        ld_addr[d] = a;
        ld_data[d] = v;
        @(negedge clk);
        while (!instr_ready[d] && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (instr_ready[d]) begin
            if (a != 5'd0) model_rf[d][a] = v;
        end else begin
            checks++;
            errors++;
            $display("FAIL load_timeout (dut%0d): got busy, want ready within 50 cycles", d);
        end
        @(posedge clk);
        #1;
        ld_en[d] = 1'b0;
    endtask

    task automatic issue(input int d, input logic [31:0] ins, input bit keep, input bit exp_wb,
                         input bit do_ld, input logic [4:0] la, input logic [31:0] lv,
                         output int acc);
        int          n = 0;
        alu_exp_t    ea;
        wb_exp_t     ew;
        logic [4:0]  rs, rt, rd;
        logic [31:0] res;
        rs = ins[25:21];
        rt = ins[20:16];
        rd = ins[15:11];
        acc = -1;
        instr[d]       = ins;
        instr_valid[d] = 1'b1;
        if (do_ld) begin
            ld_en[d]   = 1'b1;
            ld_addr[d] = la;
            ld_data[d] = lv;
        end
        @(negedge clk);
        while (!instr_ready[d] && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!instr_ready[d]) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout (dut%0d): got busy, want ready within 50 cycles", d);
            instr_valid[d] = 1'b0;
            ld_en[d]       = 1'b0;
            return;
        end
        acc = cyc;
        if (ins[31:26] == 6'd0) begin
            ea.a  = model_rf[d][rs];
            ea.b  = model_rf[d][rt];
            ea.sh = ins[10:6];
            ea.fn = ins[5:0];
            res   = alu_fn(ea.a, ea.b, ea.sh, ea.fn);
            q_alu.push_back(ea);
            if (do_ld && la != 5'd0) model_rf[d][la] = lv;
            if (rd != 5'd0 && exp_wb) begin
                ew.addr = rd;
                ew.data = res;
                q_wb.push_back(ew);
                model_rf[d][rd] = res;
            end
        end else begin
            if (do_ld && la != 5'd0) model_rf[d][la] = lv;
            if (model_ill[d] < 255) model_ill[d]++;
        end
        @(posedge clk);
        #1;
        ld_en[d] = 1'b0;
        if (!keep) instr_valid[d] = 1'b0;
    endtask

    task automatic chk_dbg(input int d, input logic [4:0] a);
        wait_idle(d);
        dbg_addr[d] = a;
        @(negedge clk);
        chk($sformatf("dbg_R%0d", a), d, dbg_data[d], model_rf[d][a]);
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish, want finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int          acc [3];
        int          dummy;
        logic [5:0]  fns [8];
        logic [31:0] ins;
        fns = '{6'h00, 6'h02, 6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h3f};

        for (int d = 0; d < NI; d++) begin
            rst_n[d]       = 1'b0;
            instr_valid[d] = 1'b0;
            instr[d]       = 32'd0;
            ld_en[d]       = 1'b0;
            ld_addr[d]     = 5'd0;
            ld_data[d]     = 32'd0;
            dbg_addr[d]    = 5'd5;
            model_ill[d]   = 0;
            for (int r = 0; r < 32; r++) model_rf[d][r] = 32'd0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < NI; d++) begin
            chk("ready_in_reset", d, 32'(instr_ready[d]), 32'd0);
            chk("rst_alu_a", d, alu_a[d], 32'd0);
            chk("rst_alu_b", d, alu_b[d], 32'd0);
            chk("rst_alu_shamt", d, 32'(alu_shamt[d]), 32'd0);
            chk("rst_alu_funct", d, 32'(alu_funct[d]), 32'd0);
            chk("rst_alu_valid", d, 32'(alu_valid[d]), 32'd0);
            chk("rst_wb_en", d, 32'(wb_en[d]), 32'd0);
            chk("rst_ill_cnt", d, 32'(ill_cnt[d]), 32'd0);
            chk("rst_dbg_R5", d, dbg_data[d], 32'd0);
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < NI; d++) rst_n[d] = 1'b1;
        @(negedge clk);
        for (int d = 0; d < NI; d++) chk("ready_after_release", d, 32'(instr_ready[d]), 32'd1);
        @(posedge clk);
        #1;

        // Basic sll: R3 = R2 << 1 = 0x8
        load(0, 5'd1, 32'h1000);
        load(0, 5'd2, 32'h4);
        issue(0, rtype(5'd1, 5'd2, 5'd3, 5'd1, 6'h00), 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, dummy);
        chk_dbg(0, 5'd3);
        $display("txn: sll R3 -> model 0x%08h", model_rf[0][3]);

        // rd = 0 never writes back
        issue(0, rtype(5'd1, 5'd2, 5'd0, 5'd0, 6'h3f), 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, dummy);
        chk_dbg(0, 5'd0);
        $display("txn: rd=0 discard");

        // Illegal opcode, then saturation of the counter
        issue(0, 32'h8C000000, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, dummy);
        @(negedge clk);
        chk("ready_after_illegal", 0, 32'(instr_ready[0]), 32'd1);
        chk("ill_cnt_one", 0, 32'(ill_cnt[0]), 32'(model_ill[0]));
        @(posedge clk);
        #1;
        for (int i = 0; i < 256; i++) begin
            ins = {6'($urandom_range(1, 63)), 26'($urandom())};
            issue(0, ins, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, dummy);
        end
        instr_valid[0] = 1'b0;
        @(negedge clk);
        chk("ill_cnt_sat", 0, 32'(ill_cnt[0]), 32'(model_ill[0]));
        @(posedge clk);
        #1;
        $display("txn: 257 illegal, ill_cnt %0d", ill_cnt[0]);

        // Load and accept in the same cycle: operand sees the old R1
        load(0, 5'd1, 32'h11);
        issue(0, rtype(5'd1, 5'd2, 5'd4, 5'd0, 6'h21), 1'b0, 1'b1, 1'b1, 5'd1, 32'h77, dummy);
        chk_dbg(0, 5'd1);
        chk_dbg(0, 5'd4);
        $display("txn: load+accept R1 now 0x%08h", model_rf[0][1]);

        // Back-to-back dependent chain on both latencies
        for (int d = 0; d < NI; d++) begin
            load(d, 5'd1, $urandom());
            load(d, 5'd2, $urandom());
            issue(d, rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h21), 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, acc[0]);
            issue(d, rtype(5'd3, 5'd1, 5'd4, 5'd0, 6'h26), 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, acc[1]);
            issue(d, rtype(5'd4, 5'd3, 5'd5, 5'd0, 6'h23), 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, acc[2]);
            chk("issue_period_1", d, 32'(acc[1] - acc[0]), 32'(lat_of(d) + 2));
            chk("issue_period_2", d, 32'(acc[2] - acc[1]), 32'(lat_of(d) + 2));
            chk_dbg(d, 5'd5);
            $display("txn: chain dut%0d accepts at %0d %0d %0d", d, acc[0], acc[1], acc[2]);
        end

        // Reset during WAIT abandons the instruction (ALU_LAT=3)
        load(1, 5'd5, 32'h55);
        issue(1, rtype(5'd1, 5'd2, 5'd7, 5'd0, 6'h21), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, dummy);
        @(posedge clk);
        #1;
        rst_n[1] = 1'b0;
        @(posedge clk);
        #1;
        for (int r = 0; r < 32; r++) model_rf[1][r] = 32'd0;
        model_ill[1] = 0;
        @(negedge clk);
        chk("rst_wait_ready", 1, 32'(instr_ready[1]), 32'd0);
        chk("rst_wait_alu_a", 1, alu_a[1], 32'd0);
        chk("rst_wait_alu_b", 1, alu_b[1], 32'd0);
        chk("rst_wait_alu_funct", 1, 32'(alu_funct[1]), 32'd0);
        chk("rst_wait_alu_valid", 1, 32'(alu_valid[1]), 32'd0);
        @(posedge clk);
        #1;
        rst_n[1] = 1'b1;
        @(negedge clk);
        chk("rst_wait_ready_release", 1, 32'(instr_ready[1]), 32'd1);
        @(posedge clk);
        #1;
        chk_dbg(1, 5'd5);
        chk_dbg(1, 5'd7);
        $display("txn: reset in WAIT, R5 0x%08h", model_rf[1][5]);

        // Randomized mix of legal, illegal and preloads
        for (int d = 0; d < NI; d++) begin
            for (int i = 0; i < 30; i++) begin
                if ($urandom_range(0, 4) == 0)
                    ins = {6'($urandom_range(1, 63)), 26'($urandom())};
                else
                    ins = rtype(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                                5'($urandom_range(0, 7)), 5'($urandom()), fns[$urandom_range(0, 7)]);
                issue(d, ins, 1'b1, 1'b1, ($urandom_range(0, 3) == 0),
                      5'($urandom_range(0, 7)), $urandom(), dummy);
                $display("txn: rand dut%0d instr 0x%08h", d, ins);
            end
            instr_valid[d] = 1'b0;
            for (int r = 0; r < 8; r++) chk_dbg(d, 5'(r));
            chk("rand_ill_cnt", d, 32'(ill_cnt[d]), 32'(model_ill[d]));
        end

        wait_idle(0);
        wait_idle(1);
        chk("alu_queue_drained", 0, 32'(q_alu.size()), 32'd0);
        chk("wb_queue_drained", 0, 32'(q_wb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter ALU_LAT, default 1, legal range 1..4: cycles from alu_valid to a valid alu_out.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 instr_valid  input  1  upstream instruction offered.
REQ-005 instr  input  32  MIPS R-type word: op[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0].
REQ-006 instr_ready  output  1  block can accept an instruction this cycle.
REQ-007 ld_en  input  1  register-file preload strobe.
REQ-008 ld_addr  input  5  preload target register.
REQ-009 ld_data  input  32  preload value.
REQ-010 alu_a  output  32  R[rs] to ALU operand a.
REQ-011 alu_b  output  32  R[rt] to ALU operand b.
REQ-012 alu_shamt  output  5  shift amount to ALU.
REQ-013 alu_funct  output  6  function code to ALU.
REQ-014 alu_valid  output  1  operands presented this cycle.
REQ-015 alu_out  input  32  ALU result.
REQ-016 wb_en, wb_addr[4:0], wb_data[31:0]  outputs  writeback strobe, target, value.
REQ-017 dbg_addr  input  5; dbg_data  output  32  combinational read of R[dbg_addr].
REQ-018 ill_cnt  output  8  count of rejected non-R-type instructions.

Function
REQ-019 Internal register file: 32 x 32 bits; R0 reads 0; writes to R0 are discarded.
REQ-020 FSM states: IDLE, EXEC, WAIT, WB; instr_ready=1 only in IDLE with rst_n high.
REQ-021 Accept = instr_valid & instr_ready; only legal when op==0.
REQ-022 On a legal accept: capture R[rs], R[rt], shamt, funct and rd into the alu_* output registers; IDLE->EXEC.
REQ-023 alu_* outputs stay stable from the accept edge until the next legal accept.
REQ-024 EXEC lasts 1 cycle with alu_valid=1; alu_valid=0 in all other states.
REQ-025 EXEC->WAIT when ALU_LAT>1; WAIT lasts ALU_LAT-1 cycles; EXEC->WB directly when ALU_LAT==1.
REQ-026 WB lasts 1 cycle: wb_en=1 when rd!=0, wb_addr=rd, wb_data=alu_out; R[rd] is written on the edge that ends WB; WB->IDLE.
REQ-027 wb_en=0 when rd==0; wb_addr and wb_data are 0 outside a WB cycle with wb_en=1.
REQ-028 Issue period for back-to-back instructions is ALU_LAT+2 cycles, accept to accept.
REQ-029 A dependent instruction reads the written-back value: the WB write completes before the next capture, and no forwarding path exists.
REQ-030 Illegal op!=0 while in IDLE: instruction consumed; no alu_valid; FSM stays in IDLE; ill_cnt+1, saturating at 255.
REQ-031 ld_en is honoured only in IDLE and ignored in EXEC, WAIT and WB.
REQ-032 Load and accept in the same cycle: the accepted instruction captures the pre-load contents; the load still completes.
REQ-033 dbg_data reflects a write starting the cycle after the write edge.

Reset
REQ-034 rst_n low at a posedge: state=IDLE; all 32 registers=0; alu_a=alu_b=0; alu_shamt=0; alu_funct=0; alu_valid=0; wb_en=0; wb_addr=0; wb_data=0; ill_cnt=0.
REQ-035 instr_ready=0 while rst_n is low; instr_ready=1 in the first cycle after release.
REQ-036 Reset asserted in EXEC, WAIT or WB abandons the instruction: no register-file write occurs.

Verification
REQ-037 Preload R1=0x1000, R2=0x4; issue rs=1, rt=2, rd=3, shamt=1, funct=0x00; bench ALU model (sll of b) returns 0x8 -> alu_a=0x1000, alu_b=0x4, alu_shamt=1, alu_funct=0 for one cycle; wb_en with wb_addr=3, wb_data=0x8 at accept+2 (ALU_LAT=1); dbg R3=0x8.
REQ-038 Issue with rd=0 and alu_out=0xDEADBEEF -> wb_en stays 0; dbg R0=0.
REQ-039 instr=0x8C000000 (op 0x23) -> alu_valid never asserts; ill_cnt=1; instr_ready=1 the next cycle. Issue 256 illegal instructions -> ill_cnt=255.
REQ-040 instr_valid held high with 3 legal instructions, second reads rd of first -> accepts every 3 cycles for ALU_LAT=1 and every 5 cycles for ALU_LAT=3; second instruction's alu_a equals first instruction's result.
REQ-041 rst_n pulsed low during WAIT (ALU_LAT=3) after preload R5=0x55 -> no wb_en; all outputs 0; dbg R5=0; instr_ready=1 after release.
REQ-042 ld_en with R1=0x77 in the same cycle as a legal accept with rs=1, where R1=0x11 before -> alu_a=0x11; dbg R1=0x77 afterwards.
